// File: rtl/uart_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_lite_pkg
// Purpose  : Shared parity-mode constants, receiver FSM encodings and helpers.
// Revision : 1.0
// ============================================================================
package uart_lite_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Purpose  : Two-flop synchronizer with a selectable reset value.
// Revision : 1.0
// ============================================================================
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/frame_recovery.sv
`default_nettype none
// ============================================================================
// Module   : frame_recovery
// Purpose  : Oversampled asynchronous serial frame receiver with majority vote,
//            parity, framing and break detection.
// Revision : 1.0
// ============================================================================
module frame_recovery
    import uart_lite_pkg::*;
#(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 break_o
);

    localparam int c_CW = $clog2(OVERSAMPLING);
    localparam int c_IW = $clog2(DATA_BITS);
    localparam int c_M  = OVERSAMPLING / 2;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(OVERSAMPLING - 1);
    localparam logic [c_CW-1:0] c_CNT_M0   = c_CW'(c_M - 1);
    localparam logic [c_CW-1:0] c_CNT_M    = c_CW'(c_M);
    localparam logic [c_CW-1:0] c_CNT_DEC  = c_CW'(c_M + 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_prev;
    logic [2:0]           r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [c_IW-1:0]      r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_s_a;
    logic                 r_s_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 r_any_one;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_break;

    logic w_vote;
    logic w_dec;
    logic w_wrap;
    logic w_fall;
    logic w_last_stop;
    logic w_frame_err;
    logic w_any;
    logic w_par_calc;
    logic w_parity_err;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_d   (rx_i),
        .o_q   (w_rx_s)
    );

    // Two earlier samples are held so the third arrives live on the decision cycle.
    assign w_vote      = maj3(r_s_a, r_s_b, w_rx_s);
    assign w_dec       = (r_cnt == c_CNT_DEC);
    assign w_wrap      = (r_cnt == c_CNT_LAST);
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
    assign w_frame_err = r_stop_err | ~w_vote;
    assign w_any       = r_any_one | w_vote;
    assign w_par_calc  = (^r_shift) ^ r_par_bit;

    always_comb begin
        w_parity_err = 1'b0;
        if (PARITY == PAR_ODD) begin
            w_parity_err = ~w_par_calc;
        end else if (PARITY == PAR_EVEN) begin
            w_parity_err = w_par_calc;
        end else if (PARITY == PAR_NONE) begin
            w_parity_err = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_prev    <= 1'b1;
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_s_a        <= 1'b1;
            r_s_b        <= 1'b1;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_any_one    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_rx_prev <= w_rx_s;

            if (r_cnt == c_CNT_M0) r_s_a <= w_rx_s;
            if (r_cnt == c_CNT_M)  r_s_b <= w_rx_s;

            if (r_state != ST_IDLE) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Edge-based arming: a line left low after a frame never restarts.
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_any_one  <= 1'b0;
                        r_par_bit  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_dec && w_vote) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_dec) begin
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_any_one <= w_any;
                    end
                    if (w_wrap) begin
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_dec) begin
                        r_par_bit <= w_vote;
                        r_any_one <= w_any;
                    end
                    if (w_wrap) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_dec) begin
                        if (w_last_stop) begin
                            r_data       <= r_shift;
                            r_frame_err  <= w_frame_err;
                            r_parity_err <= w_parity_err;
                            r_break      <= ~w_any;
                            r_valid      <= 1'b1;
                            r_state      <= ST_IDLE;
                            r_cnt        <= '0;
                        end else begin
                            r_stop_err <= w_frame_err;
                            r_any_one  <= w_any;
                        end
                    end
                    if (w_wrap) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_frame_err;
    assign parity_err_o = r_parity_err;
    assign break_o      = r_break;

endmodule
`default_nettype wire

// File: tb/tb_frame_recovery.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_recovery
// Purpose  : Directed self-checking bench for frame_recovery (8N1 and 8E1).
// Revision : 1.0
// ============================================================================
module tb_frame_recovery;

    localparam int OS  = 16;
    localparam int LAT = 2 + 1 + (1 + 8 + 0 + 1 - 1) * OS + OS / 2 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       perr_a, perr_b;
    logic       brk_a, brk_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int vcnt_a      = 0;
    int vcnt_b      = 0;
    int vcyc_a      = 0;
    int fall_cyc    = 0;
    int base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a++;
            vcyc_a = cyc;
        end
        if (valid_b) vcnt_b++;
    end

    frame_recovery #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (8),
        .PARITY       (0),
        .STOP_BITS    (1)
    ) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx_a),
        .data_o       (data_a),
        .valid_o      (valid_a),
        .frame_err_o  (ferr_a),
        .parity_err_o (perr_a),
        .break_o      (brk_a)
    );

    frame_recovery #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (8),
        .PARITY       (2),
        .STOP_BITS    (1)
    ) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx_b),
        .data_o       (data_b),
        .valid_o      (valid_b),
        .frame_err_o  (ferr_b),
        .parity_err_o (perr_b),
        .break_o      (brk_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkframe(input logic [7:0] d, input logic par_en,
                                            input logic pb, input logic stop);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (par_en) begin
            f[9]  = pb;
            f[10] = stop;
        end else begin
            f[9] = stop;
        end
        return f;
    endfunction

    // gk selects one oversample slot to invert (-1 for none).
    task automatic send(input int sel, input logic [15:0] f, input int nb, input int gk);
        logic v;
        for (int k = 0; k < nb * OS; k++) begin
            @(negedge clk);
            v = f[k / OS] ^ logic'(k == gk);
            if (sel == 0) rx_a = v;
            else          rx_b = v;
            if (k == 0) fall_cyc = cyc + 1;
        end
        @(negedge clk);
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        chk("reset_valid", 32'(valid_a), 32'd0);
        chk("reset_data",  32'(data_a),  32'd0);
        chk("reset_flags", 32'({ferr_a, perr_a, brk_a}), 32'd0);
        chk("reset_valid_count", 32'(vcnt_a), 32'd0);

        // 8N1 0xA5
        base = vcnt_a;
        send(0, mkframe(8'hA5, 1'b0, 1'b0, 1'b1), 10, -1);
        chk("a5_count",   32'(vcnt_a - base), 32'd1);
        chk("a5_data",    32'(data_a), 32'hA5);
        chk("a5_ferr",    32'(ferr_a), 32'd0);
        chk("a5_perr",    32'(perr_a), 32'd0);
        chk("a5_break",   32'(brk_a),  32'd0);
        chk("a5_latency", 32'(vcyc_a - fall_cyc), 32'(LAT));

        // 4-cycle low pulse is a false start
        base = vcnt_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_count", 32'(vcnt_a - base), 32'd0);
        send(0, mkframe(8'h3C, 1'b0, 1'b0, 1'b1), 10, -1);
        chk("3c_count", 32'(vcnt_a - base), 32'd1);
        chk("3c_data",  32'(data_a), 32'h3C);

        // glitch at count M of data bit 3 (line bit 4)
        base = vcnt_a;
        send(0, mkframe(8'h00, 1'b0, 1'b0, 1'b1), 10, 4 * OS + OS / 2 + 1);
        chk("glitch_count", 32'(vcnt_a - base), 32'd1);
        chk("glitch_data",  32'(data_a), 32'h00);
        chk("glitch_ferr",  32'(ferr_a), 32'd0);
        chk("glitch_break", 32'(brk_a),  32'd0);

        // 8E1 parity
        send(1, mkframe(8'h01, 1'b1, 1'b0, 1'b1), 11, -1);
        chk("e1_bad_count", 32'(vcnt_b), 32'd1);
        chk("e1_bad_data",  32'(data_b), 32'h01);
        chk("e1_bad_perr",  32'(perr_b), 32'd1);
        chk("e1_bad_ferr",  32'(ferr_b), 32'd0);
        send(1, mkframe(8'h01, 1'b1, 1'b1, 1'b1), 11, -1);
        chk("e1_good_count", 32'(vcnt_b), 32'd2);
        chk("e1_good_perr",  32'(perr_b), 32'd0);

        // stop bit low, then a clean frame
        base = vcnt_a;
        send(0, mkframe(8'h55, 1'b0, 1'b0, 1'b0), 10, -1);
        chk("stoplow_count", 32'(vcnt_a - base), 32'd1);
        chk("stoplow_data",  32'(data_a), 32'h55);
        chk("stoplow_ferr",  32'(ferr_a), 32'd1);
        chk("stoplow_break", 32'(brk_a),  32'd0);
        send(0, mkframe(8'h12, 1'b0, 1'b0, 1'b1), 10, -1);
        chk("after_stoplow_data", 32'(data_a), 32'h12);
        chk("after_stoplow_ferr", 32'(ferr_a), 32'd0);

        // held break for 20 bit periods
        base = vcnt_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (20 * OS) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("break_count", 32'(vcnt_a - base), 32'd1);
        chk("break_data",  32'(data_a), 32'h00);
        chk("break_ferr",  32'(ferr_a), 32'd1);
        chk("break_flag",  32'(brk_a),  32'd1);

        // reset mid-frame abandons a would-be 0xFF frame
        base = vcnt_a;
        rx_a = 1'b0;
        repeat (OS) @(negedge clk);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("midreset_count", 32'(vcnt_a - base), 32'd0);
        chk("midreset_data",  32'(data_a), 32'h00);
        send(0, mkframe(8'h5A, 1'b0, 1'b0, 1'b1), 10, -1);
        chk("post_reset_count", 32'(vcnt_a - base), 32'd1);
        chk("post_reset_data",  32'(data_a), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_recovery.md
FRAME_RECOVERY -- requirements
Module: frame_recovery

Interface
REQ-001 The block SHALL have parameter OVERSAMPLING, default 16, meaning clk_i cycles per bit period; legal values are 4..256.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values are 1 and 2.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port data_o, output, DATA_BITS wide: received data word, LSB first on the line.
REQ-009 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse marking frame completion.
REQ-010 The block SHALL have port frame_err_o, output, 1 bit: stop bit sampled low.
REQ-011 The block SHALL have port parity_err_o, output, 1 bit: parity mismatch; always 0 when PARITY=0.
REQ-012 The block SHALL have port break_o, output, 1 bit: all-zero frame, including parity and stop.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer to give rx_s; all decisions SHALL use rx_s.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-015 In IDLE, a 1->0 transition of rx_s SHALL move the FSM to START with sample counter = 0 on the next cycle.
REQ-016 With M = OVERSAMPLING/2, each bit SHALL be decided by 2-of-3 majority of rx_s at counter values M-1, M and M+1.
REQ-017 Each bit decision SHALL be taken in the cycle where counter == M+1.
REQ-018 The counter SHALL wrap from OVERSAMPLING-1 to 0, which advances to the next bit.
REQ-019 A START vote of 1 SHALL be a false start: return to IDLE with no output pulse.
REQ-020 DATA SHALL capture DATA_BITS votes LSB first.
REQ-021 The FSM SHALL then go to PAR if PARITY != 0, otherwise to STOP.
REQ-022 The parity check SHALL compute odd/even parity over the data bits plus the parity bit.
REQ-023 In STOP, on the decision cycle of the last stop bit, the block SHALL register data_o, frame_err_o, parity_err_o and break_o, and SHALL pulse valid_o for exactly 1 cycle.
REQ-024 After that decision cycle the FSM SHALL return to IDLE on the next cycle.
REQ-025 With STOP_BITS=2, frame_err_o SHALL be set if either stop vote is 0; the second stop bit SHALL still be sampled.
REQ-026 frame_err_o, parity_err_o and break_o SHALL be meaningful only while valid_o=1, and SHALL be held with data_o until the next valid_o.
REQ-027 break_o SHALL be 1 only when the data bits, the parity bit (if present) and all stop votes are 0; frame_err_o SHALL also be 1 in that case.
REQ-028 After a frame ending with rx_s low, IDLE SHALL not re-arm until rx_s has been seen high: a held break yields exactly one valid_o.
REQ-029 Falling edges of rx_s while the FSM is outside IDLE SHALL be ignored; there is no resynchronisation mid-frame.
REQ-030 Latency SHALL be fixed: valid_o asserts 2 + 1 + (1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)*OVERSAMPLING + M+1 cycles after the rx_i falling edge.

Reset
REQ-031 On rst_i=1 at a clock edge, the block SHALL set state = IDLE, counter = 0, valid_o = 0, data_o = 0, frame_err_o = 0, parity_err_o = 0, break_o = 0.
REQ-032 On reset, both synchronizer flops and the edge-detect history SHALL be set to 1, so that no spurious start follows reset.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no valid_o, and reception SHALL resume from the next start edge after release.

Structure
REQ-034 Shared package uart_lite_pkg SHALL hold the parity mode constants PAR_NONE, PAR_ODD and PAR_EVEN, and the FSM state encodings.
REQ-035 Sub-module uart_sync SHALL implement the 2-flop synchronizer with a reset value parameter; the vote and FSM logic SHALL stay inline.

Verification
REQ-036 Scenario: 8N1, OVERSAMPLING=16, frame 0xA5 -> one valid_o pulse, data_o=0xA5, all error flags 0, at the REQ-030 cycle.
REQ-037 Scenario: low pulse of 4 cycles on an idle line -> no valid_o; a following 0x3C frame -> data_o=0x3C.
REQ-038 Scenario: single-cycle inverted glitch at count M on data bit 3 of 0x00 -> data_o=0x00, no errors.
REQ-039 Scenario: 8E1, 0x01 sent with parity bit 0 -> parity_err_o=1, data_o=0x01; with parity bit 1 -> parity_err_o=0.
REQ-040 Scenario: 0x55 with stop bit low, then line high -> frame_err_o=1, break_o=0; the next 0x12 frame is received correctly.
REQ-041 Scenario: line held low for 20 bit periods -> exactly one valid_o with data_o=0x00, frame_err_o=1, break_o=1; rst_i pulsed mid-frame -> no valid_o for that frame.
